// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder
// SPI mode-0 front end for the frame-buffer write path. Bytes arriving on
// Sclk/Mosi/CSel are synchronized into the MainClkSrc domain, decoded as
// pixel commands, and resulting pixel writes are queued in a small FIFO that
// the memory arbiter drains through a req/ack handshake.

module spi_cmd_decoder #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_MAX   = 307199
) (
    input  logic              MainClkSrc,
    input  logic              Reset,
    input  logic              Sclk,
    input  logic              Mosi,
    input  logic              CSel,
    output logic              WrReq,
    output logic [ADDR_W-1:0] WrAddr,
    output logic [DATA_W-1:0] WrData,
    input  logic              WrAck,
    output logic              Overflow,
    output logic              Busy
);

    localparam int                PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(ADDR_MAX);

    localparam logic [7:0] OP_SET_ADDR = 8'h11;
    localparam logic [7:0] OP_WRITE    = 8'h20;
    localparam logic [7:0] OP_CLR_OVF  = 8'h30;

    typedef enum logic [2:0] {
        IDLE,
        ADDR2,
        ADDR1,
        ADDR0,
        DATA
    } cmdState_t;

    // SPI input synchronizers
    logic sclkSync1, sclkSync2, sclkSync3;
    logic mosiSync1, mosiSync2;
    logic cselSync1, cselSync2;
    logic sclkRise;

    // Byte assembly
    logic [2:0] bitCnt;
    logic [6:0] shiftReg;
    logic [7:0] rxByte;
    logic       byteStrobe;

    // Command decoding
    cmdState_t currentState, nextState;
    logic      captureA2, captureA1, loadPtr, pushReq, clrOvf;
    logic [2:0]        a2Reg;
    logic [7:0]        a1Reg;
    logic [ADDR_W-1:0] addrPtr;

    // Write FIFO
    logic [ADDR_W-1:0] addrMem [FIFO_DEPTH];
    logic [DATA_W-1:0] dataMem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wrIdx, rdIdx;
    logic [PTR_W:0]    fifoCount;
    logic              fifoEmpty, fifoFull;
    logic              popFire, pushFire, dropWrite;

    // Two-flop synchronizers plus a third Sclk stage for rising-edge detection;
    // chip select resets to the deselected level so no phantom frame starts.
    always_ff @(posedge MainClkSrc) begin
        if (Reset) begin
            sclkSync1 <= 1'b0;
            sclkSync2 <= 1'b0;
            sclkSync3 <= 1'b0;
            mosiSync1 <= 1'b0;
            mosiSync2 <= 1'b0;
            cselSync1 <= 1'b1;
            cselSync2 <= 1'b1;
        end else begin
            sclkSync1 <= Sclk;
            sclkSync2 <= sclkSync1;
            sclkSync3 <= sclkSync2;
            mosiSync1 <= Mosi;
            mosiSync2 <= mosiSync1;
            cselSync1 <= CSel;
            cselSync2 <= cselSync1;
        end
    end

    assign sclkRise = sclkSync2 & ~sclkSync3;

    // Shift Mosi in on each Sclk rise inside a frame; deselect drops any partial byte.
    always_ff @(posedge MainClkSrc) begin
        if (Reset) begin
            bitCnt     <= 3'd0;
            shiftReg   <= 7'd0;
            rxByte     <= 8'd0;
            byteStrobe <= 1'b0;
        end else begin
            byteStrobe <= 1'b0;
            if (cselSync2) begin
                bitCnt <= 3'd0;
            end else if (sclkRise) begin
                shiftReg <= {shiftReg[5:0], mosiSync2};
                bitCnt   <= bitCnt + 3'd1;
                if (bitCnt == 3'd7) begin
                    rxByte     <= {shiftReg, mosiSync2};
                    byteStrobe <= 1'b1;
                end
            end
        end
    end

    // Command FSM state register; chip select does not touch it so commands may span frames.
    always_ff @(posedge MainClkSrc) begin
        if (Reset) begin
            currentState <= IDLE;
        end else begin
            currentState <= nextState;
        end
    end

    // Next-state logic: every transition is gated by a completed byte.
    always_comb begin
        nextState = currentState;
        if (byteStrobe) begin
            case (currentState)
                IDLE: begin
                    if (rxByte == OP_SET_ADDR) begin
                        nextState = ADDR2;
                    end else if (rxByte == OP_WRITE) begin
                        nextState = DATA;
                    end else begin
                        nextState = IDLE;
                    end
                end
                ADDR2:   nextState = ADDR1;
                ADDR1:   nextState = ADDR0;
                ADDR0:   nextState = IDLE;
                DATA:    nextState = IDLE;
                default: nextState = IDLE;
            endcase
        end
    end

    // Per-byte actions decoded from the state the byte arrived in.
    always_comb begin
        captureA2 = 1'b0;
        captureA1 = 1'b0;
        loadPtr   = 1'b0;
        pushReq   = 1'b0;
        clrOvf    = 1'b0;
        if (byteStrobe) begin
            case (currentState)
                IDLE:    clrOvf    = (rxByte == OP_CLR_OVF);
                ADDR2:   captureA2 = 1'b1;
                ADDR1:   captureA1 = 1'b1;
                ADDR0:   loadPtr   = 1'b1;
                DATA:    pushReq   = 1'b1;
                default: ;
            endcase
        end
    end

    // Hold the upper address bytes until the final byte loads the whole pointer at once.
    always_ff @(posedge MainClkSrc) begin
        if (Reset) begin
            a2Reg <= 3'd0;
            a1Reg <= 8'd0;
        end else begin
            if (captureA2) begin
                a2Reg <= rxByte[2:0];
            end
            if (captureA1) begin
                a1Reg <= rxByte;
            end
        end
    end

    // Address pointer: loaded by SET_ADDR, advanced on every pixel (even a dropped one), wrapping at the last pixel.
    always_ff @(posedge MainClkSrc) begin
        if (Reset) begin
            addrPtr <= '0;
        end else if (loadPtr) begin
            addrPtr <= ADDR_W'({a2Reg, a1Reg, rxByte});
        end else if (pushReq) begin
            addrPtr <= (addrPtr >= ADDR_LAST) ? '0 : addrPtr + 1'b1;
        end
    end

    assign fifoEmpty = (fifoCount == '0);
    assign fifoFull  = (fifoCount == FULL_COUNT);
    assign popFire   = ~fifoEmpty & WrAck;
    assign pushFire  = pushReq & (~fifoFull | popFire);
    assign dropWrite = pushReq & fifoFull & ~popFire;

    // FIFO storage; a push into a full FIFO that pops the same cycle reuses the slot being vacated.
    always_ff @(posedge MainClkSrc) begin
        if (pushFire) begin
            addrMem[wrIdx] <= addrPtr;
            dataMem[wrIdx] <= DATA_W'(rxByte);
        end
    end

    // FIFO read/write indices and occupancy.
    always_ff @(posedge MainClkSrc) begin
        if (Reset) begin
            wrIdx     <= '0;
            rdIdx     <= '0;
            fifoCount <= '0;
        end else begin
            if (pushFire) begin
                wrIdx <= wrIdx + 1'b1;
            end
            if (popFire) begin
                rdIdx <= rdIdx + 1'b1;
            end
            case ({pushFire, popFire})
                2'b10:   fifoCount <= fifoCount + 1'b1;
                2'b01:   fifoCount <= fifoCount - 1'b1;
                default: fifoCount <= fifoCount;
            endcase
        end
    end

    // Sticky overflow flag, cleared only by reset or the CLR_OVF opcode.
    always_ff @(posedge MainClkSrc) begin
        if (Reset) begin
            Overflow <= 1'b0;
        end else if (dropWrite) begin
            Overflow <= 1'b1;
        end else if (clrOvf) begin
            Overflow <= 1'b0;
        end
    end

    // Head of the FIFO is presented straight from storage; zeros while nothing is pending.
    always_comb begin
        WrReq  = ~fifoEmpty;
        WrAddr = fifoEmpty ? '0 : addrMem[rdIdx];
        WrData = fifoEmpty ? '0 : dataMem[rdIdx];
        Busy   = (currentState != IDLE) | ~fifoEmpty;
    end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb_spi_cmd_decoder
// Drives SPI command sequences into spi_cmd_decoder and checks the write
// stream, Overflow and Busy against a command-level reference model.

module tb_spi_cmd_decoder;

    localparam int ADDR_MAX = 307199;
    localparam int DEPTH    = 4;

    logic        MainClkSrc = 1'b0;
    logic        Reset      = 1'b1;
    logic        Sclk       = 1'b0;
    logic        Mosi       = 1'b0;
    logic        CSel       = 1'b1;
    logic        WrAck      = 1'b1;
    logic        WrReq;
    logic [18:0] WrAddr;
    logic [7:0]  WrData;
    logic        Overflow;
    logic        Busy;

    int checks = 0;
    int errors = 0;

    // Reference model: pending writes as {addr, data}, pointer and overflow flag.
    logic [26:0] pending[$];
    int          modelPtr = 0;
    bit          modelOvf = 1'b0;
    bit          splitFrames = 1'b0;

    spi_cmd_decoder dut (
        .MainClkSrc(MainClkSrc),
        .Reset     (Reset),
        .Sclk      (Sclk),
        .Mosi      (Mosi),
        .CSel      (CSel),
        .WrReq     (WrReq),
        .WrAddr    (WrAddr),
        .WrData    (WrData),
        .WrAck     (WrAck),
        .Overflow  (Overflow),
        .Busy      (Busy)
    );

    // 100 MHz system clock
    always #5 MainClkSrc = ~MainClkSrc;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Every accepted handshake must deliver the oldest pending model write.
    always @(negedge MainClkSrc) begin
        logic [26:0] exp;
        if (!Reset && WrReq === 1'b1 && WrAck === 1'b1) begin
            if (pending.size() == 0) begin
                checkOutput("spuriousReq", {31'd0, WrReq}, 32'd0);
            end else begin
                exp = pending.pop_front();
                checkOutput("popAddr", {13'd0, WrAddr}, {13'd0, exp[26:8]});
                checkOutput("popData", {24'd0, WrData}, {24'd0, exp[7:0]});
            end
        end
    end

    initial begin
        #500us;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic settle();
        repeat (12) @(posedge MainClkSrc);
        #1;
    endtask

    task automatic beginFrame();
        CSel = 1'b0;
        #40;
    endtask

    task automatic endFrame();
        #40;
        CSel = 1'b1;
        #40;
    endtask

    task automatic sendBits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            Mosi = b[i];
            #20 Sclk = 1'b1;
            #20 Sclk = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        if (splitFrames) beginFrame();
        sendBits(b, 8);
        if (splitFrames) endFrame();
    endtask

    task automatic cmdSetAddr(input logic [7:0] a2, input logic [7:0] a1, input logic [7:0] a0);
        if (!splitFrames) beginFrame();
        applyStimulus(8'h11);
        applyStimulus(a2);
        applyStimulus(a1);
        applyStimulus(a0);
        if (!splitFrames) endFrame();
        modelPtr = (int'(a2[2:0]) << 16) + (int'(a1) << 8) + int'(a0);
        settle();
    endtask

    task automatic cmdWrite(input logic [7:0] d);
        if (pending.size() < DEPTH) pending.push_back({modelPtr[18:0], d});
        else modelOvf = 1'b1;
        modelPtr = (modelPtr >= ADDR_MAX) ? 0 : modelPtr + 1;
        if (!splitFrames) beginFrame();
        applyStimulus(8'h20);
        applyStimulus(d);
        if (!splitFrames) endFrame();
        settle();
    endtask

    task automatic cmdSingle(input logic [7:0] op);
        if (!splitFrames) beginFrame();
        applyStimulus(op);
        if (!splitFrames) endFrame();
        if (op == 8'h30) modelOvf = 1'b0;
        settle();
    endtask

    task automatic doReset();
        @(posedge MainClkSrc);
        #1 Reset = 1'b1;
        @(posedge MainClkSrc);
        #1 Reset = 1'b0;
        pending.delete();
        modelPtr = 0;
        modelOvf = 1'b0;
    endtask

    task automatic setAck(input logic v);
        @(posedge MainClkSrc);
        #1 WrAck = v;
    endtask

    // Quiescent-point comparison of all status outputs and the FIFO head.
    task automatic checkState(input string tag);
        checkOutput({tag, "_WrReq"}, {31'd0, WrReq}, {31'd0, pending.size() != 0});
        checkOutput({tag, "_Overflow"}, {31'd0, Overflow}, {31'd0, modelOvf});
        checkOutput({tag, "_Busy"}, {31'd0, Busy}, {31'd0, pending.size() != 0});
        if (pending.size() != 0) begin
            checkOutput({tag, "_headAddr"}, {13'd0, WrAddr}, {13'd0, pending[0][26:8]});
            checkOutput({tag, "_headData"}, {24'd0, WrData}, {24'd0, pending[0][7:0]});
        end
    endtask

    initial begin
        logic [7:0] rb;
        int         addr;
        int         r;
        logic [7:0] hi;

        repeat (4) @(posedge MainClkSrc);
        #1 Reset = 1'b0;
        #1;
        $display("[TB] reset state");
        checkOutput("rstWrReq", {31'd0, WrReq}, 32'd0);
        checkOutput("rstOverflow", {31'd0, Overflow}, 32'd0);
        checkOutput("rstBusy", {31'd0, Busy}, 32'd0);
        checkOutput("rstWrAddr", {13'd0, WrAddr}, 32'd0);
        checkOutput("rstWrData", {24'd0, WrData}, 32'd0);

        $display("[TB] single write at 0x00100");
        cmdSetAddr(8'h00, 8'h01, 8'h00);
        cmdWrite(8'hC0);
        checkState("t1");
        cmdWrite(8'($urandom));
        checkState("t1next");

        $display("[TB] fill FIFO and overflow");
        cmdSetAddr(8'h00, 8'h00, 8'h00);
        setAck(1'b0);
        repeat (5) cmdWrite(8'h55);
        checkState("t2full");
        repeat (20) @(posedge MainClkSrc);
        #1;
        checkState("t2hold");
        setAck(1'b1);
        settle();
        checkState("t2drain");
        cmdWrite(8'($urandom));
        checkState("t2after");

        $display("[TB] wrap at last address");
        splitFrames = 1'b1;
        cmdSetAddr(8'h04, 8'hAF, 8'hFF);
        cmdWrite(8'h01);
        cmdWrite(8'h02);
        checkState("t3");

        $display("[TB] partial byte dropped");
        splitFrames = 1'b0;
        beginFrame();
        sendBits(8'hA5, 4);
        endFrame();
        cmdWrite(8'h7E);
        checkState("t4");

        $display("[TB] reset mid-command");
        setAck(1'b0);
        repeat (5) cmdWrite(8'($urandom));
        beginFrame();
        sendBits(8'h11, 8);
        sendBits(8'h00, 8);
        endFrame();
        settle();
        checkOutput("t5busyMidCmd", {31'd0, Busy}, 32'd1);
        doReset();
        #1;
        checkState("t5reset");
        setAck(1'b1);
        cmdWrite(8'h33);
        checkState("t5write");

        $display("[TB] unknown opcode and overflow clear");
        setAck(1'b0);
        repeat (5) cmdWrite(8'($urandom));
        setAck(1'b1);
        settle();
        cmdSingle(8'h5A);
        cmdWrite(8'h11);
        checkState("t6ovfSet");
        cmdSingle(8'h30);
        checkState("t6ovfClr");

        $display("[TB] command spread over frames");
        splitFrames = 1'b1;
        applyStimulus(8'h11);
        settle();
        checkOutput("busyAfterOpcode", {31'd0, Busy}, 32'd1);
        applyStimulus(8'h00);
        applyStimulus(8'h02);
        applyStimulus(8'h00);
        modelPtr = 32'h200;
        settle();
        cmdWrite(8'($urandom));
        checkState("splitCmd");

        $display("[TB] randomized commands");
        for (int it = 0; it < 24; it++) begin
            splitFrames = ($urandom % 2) == 1;
            r = $urandom % 8;
            if (r < 2) begin
                if ($urandom % 2 == 1) addr = $urandom_range(ADDR_MAX, ADDR_MAX - 3);
                else addr = $urandom_range(524287, 0);
                hi = 8'($urandom);
                cmdSetAddr({hi[7:3], 3'(addr >> 16)}, 8'(addr >> 8), 8'(addr));
            end else if (r == 2) begin
                rb = 8'($urandom);
                if (rb == 8'h11 || rb == 8'h20 || rb == 8'h30) rb = 8'h5A;
                cmdSingle(rb);
            end else begin
                cmdWrite(8'($urandom));
            end
            if (it % 4 == 3) checkState("rand");
        end

        settle();
        checkState("final");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
